// File: rtl/servo_pos_ramp_if.sv
// servo_pos_ramp_if: command handshake into the position ramp.
//   cmd_pos   [9:0] requested target position (clamped to POS_MAX by the slave)
//   cmd_valid       cmd_pos is valid
//   cmd_ready       slave accepts a command this cycle
// master = command source, slave = servo_pos_ramp.
interface servo_pos_ramp_if;
  logic [9:0] cmd_pos;
  logic       cmd_valid;
  logic       cmd_ready;

  modport master (output cmd_pos, output cmd_valid, input cmd_ready);
  modport slave  (input cmd_pos, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/servo_pos_ramp.sv
// servo_pos_ramp: slew-rate-limited position generator for servoPWM.
// Moves pos toward the commanded target by at most STEP counts once per
// frame of FRAME_CYCLES clocks, so pos only changes on frame boundaries.
//
// Optional build macro SERVO_SWEEP_EN adds the sweep_req port and a SWEEP
// state that bounces pos between 0 and POS_MAX.
//
// Ports:
//   clk        system clock, posedge
//   rst        synchronous active-high reset
//   cmd        servo_pos_ramp_if.slave (cmd_pos / cmd_valid / cmd_ready)
//   sweep_req  level request for sweep mode (SERVO_SWEEP_EN only)
//   pos        registered position to servoPWM
//   frame_tick one-cycle pulse on the cycle pos updates
//   at_target  registered pos == target
//   busy       state is RAMP or SWEEP
module servo_pos_ramp #(
  parameter int FRAME_CYCLES = 2000000,
  parameter int STEP         = 10,
  parameter int POS_MAX      = 1000
) (
  input  logic             clk,
  input  logic             rst,
  servo_pos_ramp_if.slave  cmd,
`ifdef SERVO_SWEEP_EN
  input  logic             sweep_req,
`endif
  output logic [9:0]       pos,
  output logic             frame_tick,
  output logic             at_target,
  output logic             busy
);

  localparam logic [20:0]        FC_LAST   = 21'(FRAME_CYCLES - 1);
  localparam logic [10:0]        STEP_W    = 11'(STEP);
  localparam logic signed [10:0] STEP_S    = 11'(STEP);
  localparam logic [9:0]         STEP_P    = 10'(STEP);
  localparam logic [10:0]        POS_MAX_W = 11'(POS_MAX);
  localparam logic [9:0]         POS_MAX_P = 10'(POS_MAX);

`ifdef SERVO_SWEEP_EN
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RAMP  = 2'd1;
  localparam logic [1:0] S_SWEEP = 2'd2;
  logic [1:0] state, state_n;
  logic       dir, dir_n;   // 1 = up
  logic [10:0] up_sum;
`else
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RAMP = 1'b1;
  logic [0:0] state, state_n;
`endif

  logic [20:0]        fcnt;
  logic [9:0]         target, tgt_n, pos_n, clamped;
  logic signed [10:0] diff;
  logic               tick, accept;

  assign cmd.cmd_ready = ~rst;
  assign busy          = (state != S_IDLE);
  assign tick          = (fcnt == FC_LAST);
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign clamped       = ({1'b0, cmd.cmd_pos} > POS_MAX_W) ? POS_MAX_P : cmd.cmd_pos;
  // 11-bit signed so a full-stroke difference never wraps
  assign diff          = $signed({1'b0, target}) - $signed({1'b0, pos});
`ifdef SERVO_SWEEP_EN
  assign up_sum        = {1'b0, pos} + STEP_W;
`endif

  always_comb begin
    pos_n   = pos;
    tgt_n   = target;
    state_n = state;
`ifdef SERVO_SWEEP_EN
    dir_n   = dir;
`endif
    // Frame step always uses the target held before this cycle's command.
    if (tick) begin
      if (state == S_RAMP) begin
        if (diff > STEP_S)       pos_n = pos + STEP_P;
        else if (diff < -STEP_S) pos_n = pos - STEP_P;
        else                     pos_n = target;
      end
`ifdef SERVO_SWEEP_EN
      else if (state == S_SWEEP) begin
        if (dir) begin
          if (up_sum >= POS_MAX_W) begin
            pos_n = POS_MAX_P;
            dir_n = 1'b0;
          end else begin
            pos_n = up_sum[9:0];
          end
        end else begin
          if ({1'b0, pos} <= STEP_W) begin
            pos_n = '0;
            dir_n = 1'b1;
          end else begin
            pos_n = pos - STEP_P;
          end
        end
      end
`endif
    end

    // Mode selection: a command beats sweep_req; the next state is judged
    // against the post-step position so a tick/command collision keeps ramping.
    if (accept) begin
      tgt_n   = clamped;
      state_n = (pos_n != clamped) ? S_RAMP : S_IDLE;
    end
`ifdef SERVO_SWEEP_EN
    else if (state == S_SWEEP) begin
      tgt_n   = pos_n;
      state_n = sweep_req ? S_SWEEP : S_IDLE;
    end
    else if (sweep_req) begin
      tgt_n   = pos_n;
      state_n = S_SWEEP;
      dir_n   = 1'b1;
    end
`endif
    else begin
      state_n = (pos_n != target) ? S_RAMP : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt       <= '0;
      pos        <= '0;
      target     <= '0;
      state      <= S_IDLE;
      frame_tick <= 1'b0;
      at_target  <= 1'b1;
`ifdef SERVO_SWEEP_EN
      dir        <= 1'b1;
`endif
    end else begin
      fcnt       <= tick ? '0 : fcnt + 21'd1;
      pos        <= pos_n;
      target     <= tgt_n;
      state      <= state_n;
      frame_tick <= tick;
      at_target  <= (pos_n == tgt_n);
`ifdef SERVO_SWEEP_EN
      dir        <= dir_n;
`endif
    end
  end

endmodule

// File: doc/servo_pos_ramp.md
# servo_pos_ramp

Slew-rate-limited position generator feeding `servoPWM`'s `pos[9:0]` input. Accepts a target position over a valid/ready handshake and moves `pos` toward it by at most `STEP` counts once per 20 ms servo frame, so the horn never jumps a full stroke in one frame. An optional autonomous sweep mode drives `pos` back and forth between 0 and `POS_MAX`, for bench and demo use.

## Interface

Parameters:
- `FRAME_CYCLES`, default 2000000: clock cycles per servo frame (20 ms at 100 MHz). Legal range is 2 to 2^21.
- `STEP`, default 10: maximum `pos` change per frame. Legal range is 1 to `POS_MAX`.
- `POS_MAX`, default 1000: upper position limit. Must be ≤ 1023.

Ports:
- `clk`  in  1  system clock, 100 MHz; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_pos`  in  10  requested target position.
- `cmd_valid`  in  1  `cmd_pos` is valid.
- `cmd_ready`  out  1  block accepts a command this cycle.
- `sweep_req`  in  1  level; requests sweep mode. Present only with `SERVO_SWEEP_EN`.
- `pos`  out  10  position to `servoPWM`; registered.
- `frame_tick`  out  1  one-cycle pulse on the cycle `pos` updates.
- `at_target`  out  1  `pos == target`; registered.
- `busy`  out  1  state is RAMP or SWEEP.

## Operation

- Frame counter `fcnt` (21 bits) counts 0 to `FRAME_CYCLES-1`, then wraps to 0. It runs freely in every state.
- `tick` is true when `fcnt == FRAME_CYCLES-1`. `frame_tick` is `tick` registered, so it pulses on the cycle the new `pos` appears.
- `cmd_ready` is 1 whenever `rst` is 0.
- A command is accepted when `cmd_valid && cmd_ready`.
- On acceptance, `target` is loaded with `min(cmd_pos, POS_MAX)`.

States:
- IDLE: `pos == target`.
  - An accepted command with a clamped value different from `pos` moves the state to RAMP.
  - An accepted command equal to `pos` leaves the state in IDLE.
- RAMP: on each `tick`, `d = target - pos`, computed as signed 11-bit.
  - If `|d| <= STEP`, then `pos <= target` and the state goes to IDLE.
  - Otherwise `pos <= pos ± STEP`, moving toward `target`.
- SWEEP (only with the macro): on each `tick`:
  - Direction up: `pos <= min(pos+STEP, POS_MAX)`. If the result is `POS_MAX`, the direction flips to down.
  - Direction down: `pos <= max(pos-STEP, 0)`. If the result is 0, the direction flips to up.
  - Arithmetic is 11-bit, so there is no wrap below 0 or above 1023.
  - `target` tracks `pos` while sweeping.

Mode priority:
- An accepted command beats `sweep_req`: it enters RAMP from `pos`, and SWEEP is abandoned.
- `sweep_req == 1` with no command, in IDLE or RAMP, enters SWEEP on the next cycle. `pos` is retained and the direction is set to up.
- `sweep_req == 0` in SWEEP, with no command: `target <= pos` and the state goes to IDLE.

Simultaneous events and reset:
- A command accepted on a `tick` cycle: that tick's step uses the old `target`, and the new `target` takes effect from the next tick.
- `rst` mid-ramp or mid-sweep aborts immediately.

Reset values:
- `pos` = 0, `target` = 0, `fcnt` = 0, state IDLE, direction up.
- `frame_tick` = 0, `at_target` = 1, `busy` = 0, `cmd_ready` = 0.

## Timing

- Command acceptance to first `pos` change: from 1 to `FRAME_CYCLES` cycles, depending on `fcnt` phase.
- `pos`, `at_target` and `busy` change only on the cycle after `tick`, i.e. together with `frame_tick`. The exception is a state change caused by a command or `sweep_req`: `busy` and `at_target` follow one cycle after acceptance.
- Ramp duration is `ceil(|target-pos| / STEP)` frames.
- `pos` is stable for the whole frame, so `servoPWM` sees a glitch-free input.

## Configuration

- `SERVO_SWEEP_EN` defined:
  - The `sweep_req` port and the SWEEP state exist.
  - The direction register exists.
- `SERVO_SWEEP_EN` undefined:
  - The port is removed.
  - There are only two states, IDLE and RAMP.
  - Behaviour is otherwise identical.

## Test plan

All scenarios use `FRAME_CYCLES`=100, `STEP`=10, `POS_MAX`=1000.

- Reset check: hold `rst` for 3 cycles, then release → `pos`=0, `at_target`=1, `busy`=0, `cmd_ready`=1, first `frame_tick` 100 cycles after release.
- Ramp up from reset: command 35 → `pos` reads 10, 20, 30, 35 on successive `frame_tick`s; `busy` falls with the fourth tick; `at_target`=1.
- Clamp and ramp down: command 1023 → `pos` reaches 1000 and holds. Then command 995 → `pos`=995 on the next tick, with no undershoot.
- Retarget: command 500, then after 3 ticks (`pos`=30) command 0 → `pos` reads 20, 10, 0 on the next three ticks.
- Tick collision: command 200 asserted on the `tick` cycle while ramping toward 50 from 40 → that tick yields `pos`=50, then the ramp continues 60, 70, and onward to 200.
- Sweep (macro on): hold `sweep_req`=1 from `pos`=990 → ticks give 1000, 990, 980, and so on. Then drive `sweep_req`=0 → IDLE one cycle later with `at_target`=1 and `pos` frozen.
